// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the 32 x 64-bit register
//                file and its write-port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;   // XZR: writes are accepted and dropped

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [63:0]           reg_data_t;

    // Round-robin successor of requester idx among n requesters.
    function automatic int rr_succ(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches req starting at
//                ptr and wrapping; grants at most one requester, none when
//                en is low.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic found;

    // Two passes: first requesters at or above ptr, then the wrapped ones below.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (en && !found && req[i] && (PTR_W'(i) >= ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = PTR_W'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (en && !found && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = PTR_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Round-robin arbiter for the single register-file write port.
//                Stages the winning address/data for one cycle, then drives
//                the one-hot per-register enables and the write-data bus.
//                Writes to X31 (XZR) consume a grant but raise no enable.
//  Options     : REGFILE_WR_BYPASS_EN adds byp_valid/byp_addr/byp_data so the
//                decode stage can forward the staged write.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = 64,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                           clk,
    input  logic                           reset,      // async, active low
    input  logic                           hold,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]                req_ready,
    output logic [(2**ADDR_W)-1:0]         reg_enable,
    output logic [DATA_W-1:0]              wr_data,
    output logic [ADDR_W-1:0]              wr_addr
`ifdef REGFILE_WR_BYPASS_EN
    ,
    output logic                           byp_valid,
    output logic [ADDR_W-1:0]              byp_addr,
    output logic [DATA_W-1:0]              byp_data
`endif
);

    localparam int              PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [PTR_W-1:0]  rr_ptr;
    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              arb_en;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // Grants are suppressed while stalled and while reset is held, so
    // req_ready reads zero in both cases without waiting for a clock.
    assign arb_en = !hold && reset;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;   // grant is a subset of req_valid

    // One-hot mux of the winner's address and data (independent of ready).
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i];
                sel_data = req_data[i];
            end
        end
    end

    // Stage register and round-robin pointer; reset clears them immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= xfer;
            if (xfer) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
                rr_ptr    <= PTR_W'(rr_succ(int'(grant_idx), NREQ));
            end
        end
    end

    // Decode the staged address into a one-hot enable, dropping XZR writes.
    always_comb begin
        reg_enable = '0;
        if (wr_valid_q && (wr_addr_q != ZERO_ADDR)) begin
            reg_enable[wr_addr_q] = 1'b1;
        end
    end

    assign wr_data = wr_data_q;
    assign wr_addr = wr_addr_q;

`ifdef REGFILE_WR_BYPASS_EN
    assign byp_valid = wr_valid_q && (wr_addr_q != ZERO_ADDR);
    assign byp_addr  = wr_addr_q;
    assign byp_data  = wr_data_q;
`endif

endmodule : regfile_wr_arbiter
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wr_arbiter
//  Description : Directed, table-driven bench for regfile_wr_arbiter plus
//                hand-written reset, single-write and mid-cycle reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int NREQ   = 3;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NVEC   = 16;

    localparam logic [63:0] A0 = 64'h00A0_0000_0000_00A0;
    localparam logic [63:0] A1 = 64'h00A1_0000_0000_00A1;
    localparam logic [63:0] A2 = 64'h00A2_0000_0000_00A2;
    localparam logic [63:0] B0 = 64'h00B0_0000_0000_00B0;
    localparam logic [63:0] B1 = 64'h00B1_0000_0000_00B1;
    localparam logic [63:0] C1 = 64'h00C1_0000_0000_00C1;
    localparam logic [63:0] D0 = 64'h00D0_0000_0000_00D0;
    localparam logic [63:0] E0 = 64'h00E0_0000_0000_00E0;
    localparam logic [63:0] E1 = 64'h00E1_0000_0000_00E1;
    localparam logic [63:0] E2 = 64'h00E2_0000_0000_00E2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        hold;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_data;
    logic [NREQ-1:0]             req_ready;
    logic [31:0]                 reg_enable;
    logic [DATA_W-1:0]           wr_data;
    logic [ADDR_W-1:0]           wr_addr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic                        hold;
        logic [NREQ-1:0]             valid;
        logic [NREQ-1:0][ADDR_W-1:0] addr;
        logic [NREQ-1:0][DATA_W-1:0] data;
        logic [NREQ-1:0]             exp_ready;
        logic [31:0]                 exp_en;
        logic [63:0]                 exp_data;
        logic [ADDR_W-1:0]           exp_addr;
    } vec_t;

    vec_t vecs [NVEC];

    regfile_wr_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .reg_enable (reg_enable),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic h, input logic [2:0] v,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                                input logic [2:0] er, input logic [31:0] ee,
                                input logic [63:0] ed, input logic [4:0] ea);
        vec_t r;
        r.hold      = h;
        r.valid     = v;
        r.addr[0]   = a0;
        r.addr[1]   = a1;
        r.addr[2]   = a2;
        r.data[0]   = d0;
        r.data[1]   = d1;
        r.data[2]   = d2;
        r.exp_ready = er;
        r.exp_en    = ee;
        r.exp_data  = ed;
        r.exp_addr  = ea;
        return r;
    endfunction

    initial begin
        // Consecutive cycles starting right after reset release (ptr=0, stage empty).
        // Registered outputs reflect the transfer accepted in the previous row.
        vecs[0]  = mk(0, 3'b111, 1, 2, 3,   A0, A1, A2,   3'b001, 32'h0,   64'h0, 0);
        vecs[1]  = mk(0, 3'b111, 4, 2, 3,   B0, A1, A2,   3'b010, 32'h2,   A0,    1);
        vecs[2]  = mk(0, 3'b111, 4, 2, 3,   B0, A1, A2,   3'b100, 32'h4,   A1,    2);
        vecs[3]  = mk(0, 3'b011, 4, 6, 0,   B0, B1, 0,    3'b001, 32'h8,   A2,    3);
        vecs[4]  = mk(0, 3'b010, 0, 6, 0,   0,  B1, 0,    3'b010, 32'h10,  B0,    4);
        vecs[5]  = mk(0, 3'b010, 0, 7, 0,   0,  C1, 0,    3'b010, 32'h40,  B1,    6);
        vecs[6]  = mk(0, 3'b000, 0, 0, 0,   0,  0,  0,    3'b000, 32'h80,  C1,    7);
        vecs[7]  = mk(0, 3'b100, 0, 0, 31,  0,  0,  1,    3'b100, 32'h0,   C1,    7);
        vecs[8]  = mk(0, 3'b001, 0, 0, 0,   D0, 0,  0,    3'b001, 32'h0,   64'h1, 31);
        vecs[9]  = mk(1, 3'b111, 9, 10, 11, E0, E1, E2,   3'b000, 32'h1,   D0,    0);
        vecs[10] = mk(1, 3'b111, 9, 10, 11, E0, E1, E2,   3'b000, 32'h0,   D0,    0);
        vecs[11] = mk(0, 3'b111, 9, 10, 11, E0, E1, E2,   3'b010, 32'h0,   D0,    0);
        vecs[12] = mk(0, 3'b101, 9, 10, 11, E0, E1, E2,   3'b100, 32'h400, E1,    10);
        vecs[13] = mk(0, 3'b001, 9, 10, 11, E0, E1, E2,   3'b001, 32'h800, E2,    11);
        vecs[14] = mk(0, 3'b000, 0, 0, 0,   0,  0,  0,    3'b000, 32'h200, E0,    9);
        vecs[15] = mk(0, 3'b000, 0, 0, 0,   0,  0,  0,    3'b000, 32'h0,   E0,    9);

        // Reset held with all requesters valid: nothing granted, outputs clear.
        reset     = 1'b0;
        hold      = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        req_addr[0] = 5'd1;
        req_data[0] = 64'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready",  64'(req_ready),  64'h0);
        check("reset_enable", 64'(reg_enable), 64'h0);
        check("reset_wdata",  wr_data,         64'h0);
        check("reset_waddr",  64'(wr_addr),    64'h0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;

        // Table-driven sequence.
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            hold      = vecs[i].hold;
            req_valid = vecs[i].valid;
            req_addr  = vecs[i].addr;
            req_data  = vecs[i].data;
            @(negedge clk);
            check($sformatf("v%0d_ready", i),  64'(req_ready),  64'(vecs[i].exp_ready));
            check($sformatf("v%0d_enable", i), 64'(reg_enable), 64'(vecs[i].exp_en));
            check($sformatf("v%0d_wdata", i),  wr_data,         vecs[i].exp_data);
            check($sformatf("v%0d_waddr", i),  64'(wr_addr),    64'(vecs[i].exp_addr));
        end

        // Single write: requester 1 to X5 (pointer is at 1 here).
        @(posedge clk);
        #1;
        req_valid   = 3'b010;
        req_addr[1] = 5'd5;
        req_data[1] = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'h2);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("single_enable", 64'(reg_enable), 64'h20);
        check("single_wdata",  wr_data,         64'hDEAD_BEEF_0000_0001);
        check("single_waddr",  64'(wr_addr),    64'd5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("single_enable_drop", 64'(reg_enable), 64'h0);

        // Reset mid-write: requester 0 wins (pointer wraps from 2), then
        // reset is pulled low partway through the enable cycle.
        @(posedge clk);
        #1;
        req_valid   = 3'b001;
        req_addr[0] = 5'd3;
        req_data[0] = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check("midrst_ready", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        check("midrst_enable_before", 64'(reg_enable), 64'h8);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_enable_after", 64'(reg_enable), 64'h0);
        check("midrst_wdata_after",  wr_data,         64'h0);
        check("midrst_ready_after",  64'(req_ready),  64'h0);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        @(negedge clk);
        check("post_reset_first_grant", 64'(req_ready), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter
`default_nettype wire
